// File: rtl/rr_encoder_arbiter.sv
// Four-way round-robin arbiter with a registered one-hot grant and 2-bit encoded index.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN (uses HOLD_MAX).
module rr_encoder_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inA,
  input  logic       inB,
  input  logic       inC,
  input  logic       inD,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       outE0,
  output logic       outE1,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

`ifdef ARB_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  req;
  logic [1:0]  pick_idx;
  logic        pick_vld;
  logic        owner_req;
  logic        hold_limit;

  assign req        = {inD, inC, inB, inA};
  assign owner_req  = req[idx_q];
  assign hold_limit = TIMEOUT_EN && (hold_q == 8'(HOLD_MAX - 1));

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    logic [1:0] cand;
    cand     = ptr_q;
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d   = 4'b0000;
        idx_d   = 2'b00;
        valid_d = 1'b0;
        if (pick_vld) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << pick_idx;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          hold_d  = 8'd0;
        end
      end
      BUSY: begin
        if (done || !owner_req || hold_limit) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          idx_d     = 2'b00;
          valid_d   = 1'b0;
          ptr_d     = idx_q + 2'd1;
          // Pulse only when the limit alone forced the release.
          timeout_d = hold_limit && !done && owner_req;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      idx_q     <= 2'b00;
      ptr_q     <= 2'b00;
      hold_q    <= 8'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign outE0   = idx_q[0];
  assign outE1   = idx_q[1];
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed plus random stimulus for rr_encoder_arbiter against a cycle-level reference model.
// Define ARB_TIMEOUT_EN for both bench and design to exercise the hold limit.
module tb_rr_encoder_arbiter;

  localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, inA, inB, inC, inD, done;
  logic [3:0] gnt;
  logic       outE0, outE1, valid, timeout;
  logic [3:0] req;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner is -1 when nobody holds the resource.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  assign {inD, inC, inB, inA} = req;

  rr_encoder_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC), .inD(inD),
    .done(done), .gnt(gnt), .outE0(outE0), .outE1(outE1),
    .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit to_next;
    to_next = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_held  = 1;
        end
      end
    end else begin
      // m_held counts cycles the grant has already been visible.
      if (done || !req[m_owner] || (TEN && m_held >= HOLD)) begin
        to_next = TEN && (m_held >= HOLD) && !done && req[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
    m_to = to_next;
  endtask

  task automatic compare_model();
    logic [3:0] e_gnt;
    logic [1:0] e_idx;
    e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e_idx = (m_owner < 0) ? 2'b00 : 2'(m_owner);
    checks++;
    assert (gnt === e_gnt) else begin
      failures++; $error("FAIL gnt observed=%b expected=%b t=%0t", gnt, e_gnt, $time);
    end
    checks++;
    assert ({outE1, outE0} === e_idx) else begin
      failures++; $error("FAIL index observed=%b expected=%b t=%0t", {outE1, outE0}, e_idx, $time);
    end
    checks++;
    assert (valid === (m_owner >= 0)) else begin
      failures++; $error("FAIL valid observed=%b expected=%b t=%0t", valid, (m_owner >= 0), $time);
    end
    checks++;
    assert (timeout === m_to) else begin
      failures++; $error("FAIL timeout observed=%b expected=%b t=%0t", timeout, m_to, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic expect_gnt(input logic [3:0] g, input logic [1:0] ix, input string tag);
    checks++;
    assert (gnt === g) else begin
      failures++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, g);
    end
    checks++;
    assert ({outE1, outE0} === ix) else begin
      failures++; $error("FAIL %s index observed=%b expected=%b", tag, {outE1, outE0}, ix);
    end
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with all requests active.
    rst = 1'b1; req = 4'hF; done = 1'b0;
    step(); step();
    expect_gnt(4'b0000, 2'b00, "reset");
    rst = 1'b0;
    step();
    expect_gnt(4'b0001, 2'b00, "first_grant");

    // Rotation A,B,C,D,A with an idle cycle after each release.
    for (int i = 0; i < 5; i++) begin
      expect_gnt(order[i], 2'(i % 4), "rotation");
      done = 1'b1; step();
      expect_gnt(4'b0000, 2'b00, "rotation_idle");
      done = 1'b0; step();
    end
    // B granted now; serve B and C so ptr lands on D.
    done = 1'b1; step(); done = 1'b0; step();
    expect_gnt(4'b0100, 2'b10, "c_grant");
    done = 1'b1; step(); done = 1'b0;
    req = 4'b1001; step();
    expect_gnt(4'b1000, 2'b11, "wrap_d");
    done = 1'b1; step(); done = 1'b0; step();
    expect_gnt(4'b0001, 2'b00, "wrap_a");

    // Owner drop: A drops, then B granted and drops without done.
    req = 4'b0010; step(); step();
    expect_gnt(4'b0010, 2'b01, "b_grant");
    req = 4'b0000; step();
    expect_gnt(4'b0000, 2'b00, "b_drop");
    req = 4'hF; step();
    expect_gnt(4'b0100, 2'b10, "after_drop_ptr2");

    // Hold behaviour with only C requesting and no done.
    req = 4'b0100;
    if (TEN) begin
      for (int i = 0; i < HOLD - 1; i++) step();
      expect_gnt(4'b0100, 2'b10, "hold_last");
      step();
      expect_gnt(4'b0000, 2'b00, "timeout_release");
      checks++;
      assert (timeout === 1'b1) else begin
        failures++; $error("FAIL timeout_pulse observed=%b expected=1", timeout);
      end
    end else begin
      for (int i = 0; i < 22; i++) step();
      expect_gnt(4'b0100, 2'b10, "no_limit_hold");
    end
    req = 4'b0000; step(); step();

    // Reset in the middle of a D grant.
    req = 4'b1000; step(); step();
    expect_gnt(4'b1000, 2'b11, "d_busy");
    rst = 1'b1; step();
    expect_gnt(4'b0000, 2'b00, "mid_grant_reset");
    rst = 1'b0; req = 4'hF; step();
    expect_gnt(4'b0001, 2'b00, "post_reset_a");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1 && m_owner >= 0) req[m_owner] = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
